top_core: RTL and testbench

TOP_CORE -- requirements
Module: top_core

---
 rtl/top_core.sv | 50 +++++
 tb/tb_top_core.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/top_core.sv
// Moving-average pipeline: registers each input sample, keeps a 2**WIN_LOG2 deep
// shift history, and outputs the floored mean of that history one stage later.
module top_core #(
  parameter int DATA_W   = 8,
  parameter int WIN_LOG2 = 2
) (
  input  logic              CLK_I,
  input  logic              RST_X,
  input  logic [DATA_W-1:0] DATA_I,
  output logic [DATA_W-1:0] DATA_O
);

  localparam int N     = 1 << WIN_LOG2;
  localparam int SUM_W = DATA_W + WIN_LOG2;

  // Always-enabled stream: a new sample is accepted on every edge, there is
  // no valid/ready pair and nothing can stall.
  logic [DATA_W-1:0] in_q;
  logic [DATA_W-1:0] hist [N];
  logic [DATA_W-1:0] avg_q;
  logic [SUM_W-1:0]  sum_c;

  // WIN_LOG2 extra bits make the sum of N full-scale samples fit exactly.
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < N; k++) begin
      sum_c = sum_c + SUM_W'(hist[k]);
    end
  end

  always_ff @(posedge CLK_I or negedge RST_X) begin
    if (!RST_X) begin
      in_q  <= '0;
      avg_q <= '0;
      for (int k = 0; k < N; k++) begin
        hist[k] <= '0;
      end
    end else begin
      in_q    <= DATA_I;
      hist[0] <= in_q;
      for (int k = 1; k < N; k++) begin
        hist[k] <= hist[k-1];
      end
      avg_q <= sum_c[SUM_W-1:WIN_LOG2];
    end
  end

  assign DATA_O = avg_q;

endmodule

// File: tb/tb_top_core.sv
// Bench for top_core: directed reset/step/full-scale/truncation/alternating cases
// plus a randomized stream scored against a sample-window model.
module tb_top_core;

  localparam int DATA_W   = 8;
  localparam int WIN_LOG2 = 2;
  localparam int N        = 1 << WIN_LOG2;

  logic              CLK_I;
  logic              RST_X;
  logic [DATA_W-1:0] DATA_I;
  logic [DATA_W-1:0] DATA_O;

  int n_tests = 0;
  int n_fail  = 0;

  // Samples accepted since reset, oldest first; reset fills the window with zeros.
  logic [DATA_W-1:0] samp_q[$];
  logic [DATA_W-1:0] exp_q[$];

  top_core #(.DATA_W(DATA_W), .WIN_LOG2(WIN_LOG2)) dut (
    .CLK_I (CLK_I),
    .RST_X (RST_X),
    .DATA_I(DATA_I),
    .DATA_O(DATA_O)
  );

  // clock / reset
  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  // scoreboard / model
  task automatic model_reset();
    samp_q.delete();
    exp_q.delete();
    for (int i = 0; i < N + 2; i++) samp_q.push_back('0);
  endtask

  // A sample taken at edge t is averaged into DATA_O after edges t+2 .. t+N+1.
  task automatic model_push(input logic [DATA_W-1:0] d);
    int sum;
    samp_q.push_back(d);
    if (samp_q.size() > N + 2) void'(samp_q.pop_front());
    sum = 0;
    for (int i = 0; i < N; i++) sum = sum + int'(samp_q[i]);
    exp_q.push_back(DATA_W'(sum / N));
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp_v);
    end
  endtask

  // driver tasks: called at a negedge, return at the next negedge
  task automatic step(input logic [DATA_W-1:0] d, output logic [DATA_W-1:0] mv);
    DATA_I = d;
    @(posedge CLK_I);
    model_push(d);
    @(negedge CLK_I);
    mv = exp_q.pop_front();
  endtask

  task automatic tick_m(input logic [DATA_W-1:0] d, input string tag);
    logic [DATA_W-1:0] mv;
    step(d, mv);
    check(tag, DATA_O, mv);
  endtask

  task automatic tick_c(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp_v,
                        input string tag);
    logic [DATA_W-1:0] mv;
    step(d, mv);
    check(tag, DATA_O, exp_v);
  endtask

  task automatic hold_reset(input int cycles);
    @(negedge CLK_I);
    RST_X = 1'b0;
    model_reset();
    for (int i = 0; i < cycles; i++) begin
      DATA_I = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      @(posedge CLK_I);
      @(negedge CLK_I);
      check("rst_hold", DATA_O, '0);
    end
    RST_X = 1'b1;
  endtask

  // Half-cycle reset pulse inside the low clock phase, starting at a negedge.
  task automatic pulse_reset();
    #1 RST_X = 1'b0;
    #1 check("rst_async", DATA_O, '0);
    #2 RST_X = 1'b1;
    model_reset();
  endtask

  task automatic step_seq(input string tag);
    logic [DATA_W-1:0] exp_v [8];
    exp_v = '{8'h00, 8'h00, 8'h15, 8'h2A, 8'h3F, 8'h55, 8'h55, 8'h55};
    tick_c(8'h00, 8'h00, {tag, "_e1"});
    for (int i = 0; i < 8; i++) tick_c(8'h55, exp_v[i], {tag, "_ramp"});
  endtask

  initial begin
    logic [DATA_W-1:0] ff_exp [8];
    RST_X  = 1'b0;
    DATA_I = '0;
    model_reset();
    repeat (2) @(negedge CLK_I);

    hold_reset(5);
    step_seq("step");

    pulse_reset();
    step_seq("restep");

    hold_reset(2);
    ff_exp = '{8'h00, 8'h00, 8'h3F, 8'h7F, 8'hBF, 8'hFF, 8'hFF, 8'hFF};
    for (int i = 0; i < 8; i++) tick_c(8'hFF, ff_exp[i], "full_scale");

    // Window {01,00,00,00} after edge 3, {03,01,00,00} after edge 4.
    hold_reset(2);
    tick_c(8'h01, 8'h00, "trunc_e1");
    tick_c(8'h03, 8'h00, "trunc_e2");
    tick_c(8'h00, 8'h00, "trunc_a");
    tick_c(8'h00, 8'h01, "trunc_b");
    for (int i = 0; i < 4; i++) tick_m(8'h00, "trunc_tail");

    hold_reset(2);
    for (int i = 1; i <= 24; i++) begin
      if (i >= N + 1) tick_c((i % 2) ? 8'hFF : 8'h00, 8'h7F, "alt_steady");
      else            tick_m((i % 2) ? 8'hFF : 8'h00, "alt_fill");
    end

    hold_reset(2);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) pulse_reset();
      tick_m(DATA_W'($urandom_range(0, (1 << DATA_W) - 1)), "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
